udma_ch_addrgen_2d: RTL and testbench
=====================================

# udma_ch_addrgen_2d

Parametrised next-generation address generator for one uDMA channel. Adds 2D transfers (row length plus row stride) and a full shadow configuration slot, so a queued transfer is applied exactly at the end of the current one. It sits between the channel's configuration registers and the uDMA TX/RX arbiter. On every granted beat it produces the L2 address, the remaining byte count, and end-of-row/end-of-transfer events.

## Interface
- L2_AWIDTH_NOAL, 19, byte-address width (non-aligned L2 address)
- TRANS_SIZE, 20, width of the size and row-length counters
- STRIDE_SIZE, 19, width of the row stride (≤ L2_AWIDTH_NOAL)

Ports:
- clk_i  in  1  clock; single clock domain
- rstn_i  in  1  reset, synchronous and active-low
- cfg_startaddr_i  in  L2_AWIDTH_NOAL  start byte address
- cfg_size_i  in  TRANS_SIZE  total bytes to transfer
- cfg_rowlen_i  in  TRANS_SIZE  bytes per row (2D only)
- cfg_stride_i  in  STRIDE_SIZE  byte distance between row starts (2D only)
- cfg_2d_i  in  1  1 = 2D mode, 0 = linear
- cfg_continuous_i  in  1  auto-reload at end of transfer
- cfg_en_i  in  1  one-cycle pulse: start, or queue a transfer
- cfg_clr_i  in  1  one-cycle pulse: abort and flush
- int_datasize_i  in  2  beat size: 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = reserved (treated as 4 B)
- int_not_stall_i  in  1  datapath can accept a beat
- int_ch_grant_i  in  1  arbiter grant
- int_ch_curr_addr_o  out  L2_AWIDTH_NOAL  address of the next beat
- int_ch_bytes_left_o  out  TRANS_SIZE  bytes remaining, including the next beat
- int_ch_en_o  out  1  channel active
- int_ch_pending_o  out  1  shadow slot holds a queued transfer
- int_ch_sot_o  out  1  start-of-transfer pulse
- int_ch_row_event_o  out  1  end-of-row pulse
- int_ch_events_o  out  1  end-of-transfer pulse

## Operation
- Beat fires when `fire = r_en & int_ch_grant_i & int_not_stall_i`. `step` = beat size in bytes.
- Registers: active config (start, size, rowlen, stride, 2d), working state (addr, row_base, bytes_left, row_left), shadow config plus pending flag.
- States:
  - IDLE: r_en = 0.
  - RUN: r_en = 1.
- IDLE + cfg_en_i:
  - Latch cfg_* into active config.
  - Set addr = row_base = start, bytes_left = size, row_left = rowlen.
  - Go to RUN; sot pulses.
- RUN + cfg_en_i, not on a last beat: latch cfg_* into the shadow and set pending = 1. A further cfg_en_i overwrites the shadow (last write wins).
- Non-last fire (bytes_left > step):
  - bytes_left −= step.
  - In 2D mode with rowlen ≠ 0 and row_left ≤ step (row end): row_base += stride; addr = new row_base; row_left = rowlen; row_event pulses.
  - Otherwise: addr += step; row_left −= step.
- Last fire (bytes_left ≤ step, including size 0): events pulses. Then, by priority:
  1. cfg_en_i in the same cycle: load cfg_* directly; pending stays unchanged.
  2. pending: load the shadow, clear pending.
  3. cfg_continuous_i: reload the active config.
  4. Otherwise: go to IDLE and zero addr, bytes_left, row_left.
  - In cases 1–3, sot pulses and the channel stays in RUN.
- cfg_clr_i has highest priority over cfg_en_i and fire:
  - Go to IDLE; zero all working state; pending = 0.
  - No event pulse is generated.
- Arithmetic:
  - Address adds wrap modulo 2^L2_AWIDTH_NOAL.
  - Stride is zero-extended (forward strides only).
  - Counters never underflow: the last-beat check precedes any subtraction.
- When the row end and the transfer end coincide, only events pulses; row_event does not.

## Timing
- All outputs are registered.
- Reset values: every output is 0, and pending is 0.
- int_ch_en_o rises the cycle after cfg_en_i is sampled in IDLE; sot is high in that same cycle (1 cycle).
- addr and bytes_left update the cycle after each fire. Zero-bubble back-to-back fires are supported.
- events, row_event and sot are 1-cycle pulses in the cycle after the causing fire.
- On a reload (cases 1–3) en stays high continuously; the first address of the new transfer is valid the cycle after the last fire.
- int_ch_pending_o rises the cycle after the queuing cfg_en_i and falls the cycle after the last fire.
- rstn_i low mid-transfer: all state clears on that edge; no event pulses.

## Structure
- Package `udma_addrgen_pkg`:
  - datasize enum (`DS_BYTE`, `DS_HALF`, `DS_WORD`, `DS_RSVD`)
  - `ds_to_step()` function
  - state enum (`AG_IDLE`, `AG_RUN`)
- Sub-module `udma_addrgen_cfg_shadow`: shadow config registers plus pending flag, with load, consume and flush ports.
- The top level holds the FSM, counters and address datapath.

## Test plan
1. Linear, start = 0x100, size = 8, ds = 01, grant held → addresses 0x100, 0x102, 0x104, 0x106; events pulse once; en falls the cycle after the 4th fire.
2. 2D, start = 0x1000, size = 16, rowlen = 4, stride = 0x40, ds = 10 → addresses 0x1000, 0x1040, 0x1080, 0x10C0; row_event after fires 1–3 only; events after fire 4.
3. Queue: during a size = 8, ds = 00 transfer, pulse cfg_en_i with start = 0x200, size = 2 → pending = 1; after fire 8, addr = 0x200, sot pulses, pending = 0, en never drops.
4. Continuous, size = 4, ds = 10, start = 0x40 → every fire reloads addr 0x40; events pulses every beat.
5. cfg_clr_i asserted together with cfg_en_i and a fire mid-transfer → next cycle en = 0, addr = 0, pending = 0, no events pulse.
6. ds = 11 with size = 3 → one beat of 4 B, events pulses; then address wrap at 0x7FFFC + 4 → 0x00000.

Source files
------------

// File: rtl/udma_addrgen_pkg.sv
// Shared types and helpers for the 2D uDMA channel address generator.
package udma_addrgen_pkg;

   typedef enum logic [1:0] {
      DS_BYTE = 2'b00,
      DS_HALF = 2'b01,
      DS_WORD = 2'b10,
      DS_RSVD = 2'b11
   } datasize_e;

   typedef enum logic {
      AG_IDLE = 1'b0,
      AG_RUN  = 1'b1
   } ag_state_e;

   localparam int unsigned STEP_W = 3;

   // Reserved encoding behaves as a word beat.
   function automatic logic [STEP_W-1:0] ds_to_step(input datasize_e ds);
      case (ds)
         DS_BYTE: return 3'd1;
         DS_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/udma_addrgen_cfg_shadow.sv
// Shadow configuration slot: holds one queued transfer until the active one ends.
module udma_addrgen_cfg_shadow
   import udma_addrgen_pkg::*;
#(
   parameter int unsigned L2_AWIDTH_NOAL = 19,
   parameter int unsigned TRANS_SIZE     = 20,
   parameter int unsigned STRIDE_SIZE    = 19
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      load_i,
   input  logic                      consume_i,
   input  logic                      flush_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
   input  logic [TRANS_SIZE-1:0]     cfg_size_i,
   input  logic [TRANS_SIZE-1:0]     cfg_rowlen_i,
   input  logic [STRIDE_SIZE-1:0]    cfg_stride_i,
   input  logic                      cfg_2d_i,
   output logic [L2_AWIDTH_NOAL-1:0] sh_startaddr_o,
   output logic [TRANS_SIZE-1:0]     sh_size_o,
   output logic [TRANS_SIZE-1:0]     sh_rowlen_o,
   output logic [STRIDE_SIZE-1:0]    sh_stride_o,
   output logic                      sh_2d_o,
   output logic                      pending_o
);

   logic [L2_AWIDTH_NOAL-1:0] startaddr_q, startaddr_d;
   logic [TRANS_SIZE-1:0]     size_q, size_d;
   logic [TRANS_SIZE-1:0]     rowlen_q, rowlen_d;
   logic [STRIDE_SIZE-1:0]    stride_q, stride_d;
   logic                      is_2d_q, is_2d_d;
   logic                      pending_q, pending_d;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      startaddr_d = startaddr_q;
      size_d      = size_q;
      rowlen_d    = rowlen_q;
      stride_d    = stride_q;
      is_2d_d     = is_2d_q;
      pending_d   = pending_q;
      if (flush_i) begin
         pending_d = 1'b0;
      end else if (load_i) begin
         startaddr_d = cfg_startaddr_i;
         size_d      = cfg_size_i;
         rowlen_d    = cfg_rowlen_i;
         stride_d    = cfg_stride_i;
         is_2d_d     = cfg_2d_i;
         pending_d   = 1'b1;
      end else if (consume_i) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: data registers are reset too so the slot never exposes X when pending is low.
      if (!rstn_i) begin
         startaddr_q <= '0;
         size_q      <= '0;
         rowlen_q    <= '0;
         stride_q    <= '0;
         is_2d_q     <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         startaddr_q <= startaddr_d;
         size_q      <= size_d;
         rowlen_q    <= rowlen_d;
         stride_q    <= stride_d;
         is_2d_q     <= is_2d_d;
         pending_q   <= pending_d;
      end
   end

   assign sh_startaddr_o = startaddr_q;
   assign sh_size_o      = size_q;
   assign sh_rowlen_o    = rowlen_q;
   assign sh_stride_o    = stride_q;
   assign sh_2d_o        = is_2d_q;
   assign pending_o      = pending_q;

endmodule

// File: rtl/udma_ch_addrgen_2d.sv
// uDMA channel address generator with 2D (row/stride) transfers and a queued shadow config.
module udma_ch_addrgen_2d
   import udma_addrgen_pkg::*;
#(
   parameter int unsigned L2_AWIDTH_NOAL = 19,
   parameter int unsigned TRANS_SIZE     = 20,
   parameter int unsigned STRIDE_SIZE    = 19
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
   input  logic [TRANS_SIZE-1:0]     cfg_size_i,
   input  logic [TRANS_SIZE-1:0]     cfg_rowlen_i,
   input  logic [STRIDE_SIZE-1:0]    cfg_stride_i,
   input  logic                      cfg_2d_i,
   input  logic                      cfg_continuous_i,
   input  logic                      cfg_en_i,
   input  logic                      cfg_clr_i,
   input  logic [1:0]                int_datasize_i,
   input  logic                      int_not_stall_i,
   input  logic                      int_ch_grant_i,
   output logic [L2_AWIDTH_NOAL-1:0] int_ch_curr_addr_o,
   output logic [TRANS_SIZE-1:0]     int_ch_bytes_left_o,
   output logic                      int_ch_en_o,
   output logic                      int_ch_pending_o,
   output logic                      int_ch_sot_o,
   output logic                      int_ch_row_event_o,
   output logic                      int_ch_events_o
);

   ag_state_e                 state_q, state_d;
   logic [L2_AWIDTH_NOAL-1:0] start_q, start_d, addr_q, addr_d, row_base_q, row_base_d;
   logic [TRANS_SIZE-1:0]     size_q, size_d, rowlen_q, rowlen_d;
   logic [TRANS_SIZE-1:0]     bytes_left_q, bytes_left_d, row_left_q, row_left_d;
   logic [STRIDE_SIZE-1:0]    stride_q, stride_d;
   logic                      is_2d_q, is_2d_d;
   logic                      sot_q, sot_d, row_event_q, row_event_d, events_q, events_d;

   logic [L2_AWIDTH_NOAL-1:0] sh_start, ld_start;
   logic [TRANS_SIZE-1:0]     sh_size, sh_rowlen, ld_size, ld_rowlen;
   logic [STRIDE_SIZE-1:0]    sh_stride, ld_stride;
   logic                      sh_2d, sh_pending, ld_2d, do_load;

   logic [TRANS_SIZE-1:0]     step;
   logic [L2_AWIDTH_NOAL-1:0] step_a;
   logic                      running, fire, last_beat, row_end, sh_load, sh_consume;

   assign step      = TRANS_SIZE'(ds_to_step(datasize_e'(int_datasize_i)));
   assign step_a    = L2_AWIDTH_NOAL'(ds_to_step(datasize_e'(int_datasize_i)));
   assign running   = (state_q == AG_RUN);
   assign fire      = running & int_ch_grant_i & int_not_stall_i;
   // Last-beat test is done before any subtraction so bytes_left cannot underflow.
   assign last_beat = (bytes_left_q <= step);
   assign row_end   = is_2d_q & (rowlen_q != '0) & (row_left_q <= step);
   assign sh_load    = running & cfg_en_i & ~(fire & last_beat) & ~cfg_clr_i;
   assign sh_consume = fire & last_beat & ~cfg_en_i & sh_pending & ~cfg_clr_i;

   udma_addrgen_cfg_shadow #(
      .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
      .TRANS_SIZE     (TRANS_SIZE),
      .STRIDE_SIZE    (STRIDE_SIZE)
   ) u_shadow (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .load_i          (sh_load),
      .consume_i       (sh_consume),
      .flush_i         (cfg_clr_i),
      .cfg_startaddr_i (cfg_startaddr_i),
      .cfg_size_i      (cfg_size_i),
      .cfg_rowlen_i    (cfg_rowlen_i),
      .cfg_stride_i    (cfg_stride_i),
      .cfg_2d_i        (cfg_2d_i),
      .sh_startaddr_o  (sh_start),
      .sh_size_o       (sh_size),
      .sh_rowlen_o     (sh_rowlen),
      .sh_stride_o     (sh_stride),
      .sh_2d_o         (sh_2d),
      .pending_o       (sh_pending)
   );

   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      size_d       = size_q;
      rowlen_d     = rowlen_q;
      stride_d     = stride_q;
      is_2d_d      = is_2d_q;
      addr_d       = addr_q;
      row_base_d   = row_base_q;
      bytes_left_d = bytes_left_q;
      row_left_d   = row_left_q;
      sot_d        = 1'b0;
      row_event_d  = 1'b0;
      events_d     = 1'b0;
      do_load      = 1'b0;
      ld_start     = start_q;
      ld_size      = size_q;
      ld_rowlen    = rowlen_q;
      ld_stride    = stride_q;
      ld_2d        = is_2d_q;

      if (cfg_clr_i) begin
         state_d      = AG_IDLE;
         addr_d       = '0;
         row_base_d   = '0;
         bytes_left_d = '0;
         row_left_d   = '0;
      end else if (!running) begin
         if (cfg_en_i) begin
            do_load   = 1'b1;
            ld_start  = cfg_startaddr_i;
            ld_size   = cfg_size_i;
            ld_rowlen = cfg_rowlen_i;
            ld_stride = cfg_stride_i;
            ld_2d     = cfg_2d_i;
         end
      end else if (fire) begin
         if (last_beat) begin
            events_d = 1'b1;
            // Reload priority: same-cycle config, then queued shadow, then continuous.
            if (cfg_en_i) begin
               do_load   = 1'b1;
               ld_start  = cfg_startaddr_i;
               ld_size   = cfg_size_i;
               ld_rowlen = cfg_rowlen_i;
               ld_stride = cfg_stride_i;
               ld_2d     = cfg_2d_i;
            end else if (sh_pending) begin
               do_load   = 1'b1;
               ld_start  = sh_start;
               ld_size   = sh_size;
               ld_rowlen = sh_rowlen;
               ld_stride = sh_stride;
               ld_2d     = sh_2d;
            end else if (cfg_continuous_i) begin
               do_load = 1'b1;
            end else begin
               state_d      = AG_IDLE;
               addr_d       = '0;
               row_base_d   = '0;
               bytes_left_d = '0;
               row_left_d   = '0;
            end
         end else begin
            bytes_left_d = bytes_left_q - step;
            if (row_end) begin
               row_base_d  = row_base_q + L2_AWIDTH_NOAL'(stride_q);
               addr_d      = row_base_d;
               row_left_d  = rowlen_q;
               row_event_d = 1'b1;
            end else begin
               addr_d     = addr_q + step_a;
               row_left_d = (row_left_q > step) ? row_left_q - step : '0;
            end
         end
      end

      if (do_load) begin
         state_d      = AG_RUN;
         start_d      = ld_start;
         size_d       = ld_size;
         rowlen_d     = ld_rowlen;
         stride_d     = ld_stride;
         is_2d_d      = ld_2d;
         addr_d       = ld_start;
         row_base_d   = ld_start;
         bytes_left_d = ld_size;
         row_left_d   = ld_rowlen;
         sot_d        = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state uses non-blocking assignments so all flops update together at the edge.
      if (!rstn_i) begin
         state_q      <= AG_IDLE;
         start_q      <= '0;
         size_q       <= '0;
         rowlen_q     <= '0;
         stride_q     <= '0;
         is_2d_q      <= 1'b0;
         addr_q       <= '0;
         row_base_q   <= '0;
         bytes_left_q <= '0;
         row_left_q   <= '0;
         sot_q        <= 1'b0;
         row_event_q  <= 1'b0;
         events_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         size_q       <= size_d;
         rowlen_q     <= rowlen_d;
         stride_q     <= stride_d;
         is_2d_q      <= is_2d_d;
         addr_q       <= addr_d;
         row_base_q   <= row_base_d;
         bytes_left_q <= bytes_left_d;
         row_left_q   <= row_left_d;
         sot_q        <= sot_d;
         row_event_q  <= row_event_d;
         events_q     <= events_d;
      end
   end

   assign int_ch_curr_addr_o  = addr_q;
   assign int_ch_bytes_left_o = bytes_left_q;
   assign int_ch_en_o         = running;
   assign int_ch_pending_o    = sh_pending;
   assign int_ch_sot_o        = sot_q;
   assign int_ch_row_event_o  = row_event_q;
   assign int_ch_events_o     = events_q;

endmodule

// File: tb/tb_udma_ch_addrgen_2d.sv
// Directed bench for udma_ch_addrgen_2d with hand-computed expected outputs.
module tb_udma_ch_addrgen_2d;

   logic        clk_i;
   logic        rstn_i;
   logic [18:0] cfg_startaddr_i;
   logic [19:0] cfg_size_i;
   logic [19:0] cfg_rowlen_i;
   logic [18:0] cfg_stride_i;
   logic        cfg_2d_i;
   logic        cfg_continuous_i;
   logic        cfg_en_i;
   logic        cfg_clr_i;
   logic [1:0]  int_datasize_i;
   logic        int_not_stall_i;
   logic        int_ch_grant_i;
   logic [18:0] int_ch_curr_addr_o;
   logic [19:0] int_ch_bytes_left_o;
   logic        int_ch_en_o;
   logic        int_ch_pending_o;
   logic        int_ch_sot_o;
   logic        int_ch_row_event_o;
   logic        int_ch_events_o;

   int checks   = 0;
   int failures = 0;

   udma_ch_addrgen_2d #(
      .L2_AWIDTH_NOAL (19),
      .TRANS_SIZE     (20),
      .STRIDE_SIZE    (19)
   ) dut (
      .clk_i               (clk_i),
      .rstn_i              (rstn_i),
      .cfg_startaddr_i     (cfg_startaddr_i),
      .cfg_size_i          (cfg_size_i),
      .cfg_rowlen_i        (cfg_rowlen_i),
      .cfg_stride_i        (cfg_stride_i),
      .cfg_2d_i            (cfg_2d_i),
      .cfg_continuous_i    (cfg_continuous_i),
      .cfg_en_i            (cfg_en_i),
      .cfg_clr_i           (cfg_clr_i),
      .int_datasize_i      (int_datasize_i),
      .int_not_stall_i     (int_not_stall_i),
      .int_ch_grant_i      (int_ch_grant_i),
      .int_ch_curr_addr_o  (int_ch_curr_addr_o),
      .int_ch_bytes_left_o (int_ch_bytes_left_o),
      .int_ch_en_o         (int_ch_en_o),
      .int_ch_pending_o    (int_ch_pending_o),
      .int_ch_sot_o        (int_ch_sot_o),
      .int_ch_row_event_o  (int_ch_row_event_o),
      .int_ch_events_o     (int_ch_events_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic en, input logic [18:0] addr,
                             input logic [19:0] bytes, input logic sot, input logic row_ev,
                             input logic evt, input logic pend);
      check({tag, "_en"},    32'(int_ch_en_o),         32'(en));
      check({tag, "_addr"},  32'(int_ch_curr_addr_o),  32'(addr));
      check({tag, "_bytes"}, 32'(int_ch_bytes_left_o), 32'(bytes));
      check({tag, "_sot"},   32'(int_ch_sot_o),        32'(sot));
      check({tag, "_row"},   32'(int_ch_row_event_o),  32'(row_ev));
      check({tag, "_evt"},   32'(int_ch_events_o),     32'(evt));
      check({tag, "_pend"},  32'(int_ch_pending_o),    32'(pend));
   endtask

   task automatic set_cfg(input logic [18:0] start, input logic [19:0] size,
                          input logic [19:0] rowlen, input logic [18:0] stride,
                          input logic is_2d, input logic [1:0] ds);
      cfg_startaddr_i = start;
      cfg_size_i      = size;
      cfg_rowlen_i    = rowlen;
      cfg_stride_i    = stride;
      cfg_2d_i        = is_2d;
      int_datasize_i  = ds;
   endtask

   initial begin
      rstn_i           = 1'b0;
      cfg_continuous_i = 1'b0;
      cfg_en_i         = 1'b0;
      cfg_clr_i        = 1'b0;
      int_not_stall_i  = 1'b1;
      int_ch_grant_i   = 1'b0;
      set_cfg(19'h0, 20'h0, 20'h0, 19'h0, 1'b0, 2'b00);
      tick();
      tick();
      expect_out("reset", 0, 19'h0, 20'h0, 0, 0, 0, 0);
      rstn_i = 1'b1;

      // Linear, half-word beats, grant held throughout.
      set_cfg(19'h100, 20'd8, 20'd0, 19'h0, 1'b0, 2'b01);
      cfg_en_i       = 1'b1;
      int_ch_grant_i = 1'b1;
      tick();
      expect_out("lin_start", 1, 19'h100, 20'd8, 1, 0, 0, 0);
      cfg_en_i = 1'b0;
      tick();
      expect_out("lin_f1", 1, 19'h102, 20'd6, 0, 0, 0, 0);
      tick();
      expect_out("lin_f2", 1, 19'h104, 20'd4, 0, 0, 0, 0);
      tick();
      expect_out("lin_f3", 1, 19'h106, 20'd2, 0, 0, 0, 0);
      tick();
      expect_out("lin_f4", 0, 19'h0, 20'd0, 0, 0, 1, 0);
      int_ch_grant_i = 1'b0;
      tick();
      expect_out("lin_idle", 0, 19'h0, 20'd0, 0, 0, 0, 0);

      // 2D: four rows of one word each, stride 0x40.
      set_cfg(19'h1000, 20'd16, 20'd4, 19'h40, 1'b1, 2'b10);
      cfg_en_i = 1'b1;
      tick();
      expect_out("d2_start", 1, 19'h1000, 20'd16, 1, 0, 0, 0);
      cfg_en_i       = 1'b0;
      int_ch_grant_i = 1'b1;
      tick();
      expect_out("d2_f1", 1, 19'h1040, 20'd12, 0, 1, 0, 0);
      tick();
      expect_out("d2_f2", 1, 19'h1080, 20'd8, 0, 1, 0, 0);
      tick();
      expect_out("d2_f3", 1, 19'h10C0, 20'd4, 0, 1, 0, 0);
      tick();
      expect_out("d2_f4", 0, 19'h0, 20'd0, 0, 0, 1, 0);
      int_ch_grant_i = 1'b0;

      // Queue a second transfer during an 8-byte linear transfer.
      set_cfg(19'h300, 20'd8, 20'd0, 19'h0, 1'b0, 2'b00);
      cfg_en_i = 1'b1;
      tick();
      expect_out("q_start", 1, 19'h300, 20'd8, 1, 0, 0, 0);
      set_cfg(19'h200, 20'd2, 20'd0, 19'h0, 1'b0, 2'b00);
      int_ch_grant_i = 1'b1;
      tick();
      expect_out("q_f1", 1, 19'h301, 20'd7, 0, 0, 0, 1);
      cfg_en_i = 1'b0;
      for (int k = 2; k <= 7; k++) begin
         tick();
         expect_out("q_mid", 1, 19'h300 + 19'(k), 20'd8 - 20'(k), 0, 0, 0, 1);
      end
      tick();
      expect_out("q_reload", 1, 19'h200, 20'd2, 1, 0, 1, 0);
      tick();
      expect_out("q2_f1", 1, 19'h201, 20'd1, 0, 0, 0, 0);
      tick();
      expect_out("q2_f2", 0, 19'h0, 20'd0, 0, 0, 1, 0);
      int_ch_grant_i = 1'b0;

      // Continuous single-beat transfer reloads on every fire.
      set_cfg(19'h40, 20'd4, 20'd0, 19'h0, 1'b0, 2'b10);
      cfg_continuous_i = 1'b1;
      cfg_en_i         = 1'b1;
      tick();
      expect_out("c_start", 1, 19'h40, 20'd4, 1, 0, 0, 0);
      cfg_en_i       = 1'b0;
      int_ch_grant_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         expect_out("c_beat", 1, 19'h40, 20'd4, 1, 0, 1, 0);
      end
      cfg_continuous_i = 1'b0;
      tick();
      expect_out("c_stop", 0, 19'h0, 20'd0, 0, 0, 1, 0);
      int_ch_grant_i = 1'b0;

      // Clear wins over a same-cycle enable and fire, and flushes the shadow.
      set_cfg(19'h500, 20'd16, 20'd0, 19'h0, 1'b0, 2'b00);
      cfg_en_i = 1'b1;
      tick();
      expect_out("clr_start", 1, 19'h500, 20'd16, 1, 0, 0, 0);
      int_ch_grant_i = 1'b1;
      tick();
      expect_out("clr_queue", 1, 19'h501, 20'd15, 0, 0, 0, 1);
      cfg_clr_i = 1'b1;
      tick();
      expect_out("clr_hit", 0, 19'h0, 20'd0, 0, 0, 0, 0);
      cfg_clr_i      = 1'b0;
      cfg_en_i       = 1'b0;
      int_ch_grant_i = 1'b0;
      tick();
      expect_out("clr_after", 0, 19'h0, 20'd0, 0, 0, 0, 0);

      // Reserved datasize acts as 4 bytes: size 3 finishes in one beat.
      set_cfg(19'h10, 20'd3, 20'd0, 19'h0, 1'b0, 2'b11);
      cfg_en_i = 1'b1;
      tick();
      expect_out("rsvd_start", 1, 19'h10, 20'd3, 1, 0, 0, 0);
      cfg_en_i       = 1'b0;
      int_ch_grant_i = 1'b1;
      tick();
      expect_out("rsvd_f1", 0, 19'h0, 20'd0, 0, 0, 1, 0);
      int_ch_grant_i = 1'b0;

      // Address wrap, with a stalled cycle that must not advance.
      set_cfg(19'h7FFFC, 20'd8, 20'd0, 19'h0, 1'b0, 2'b10);
      cfg_en_i = 1'b1;
      tick();
      expect_out("wrap_start", 1, 19'h7FFFC, 20'd8, 1, 0, 0, 0);
      cfg_en_i        = 1'b0;
      int_ch_grant_i  = 1'b1;
      int_not_stall_i = 1'b0;
      tick();
      expect_out("wrap_stall", 1, 19'h7FFFC, 20'd8, 0, 0, 0, 0);
      int_not_stall_i = 1'b1;
      tick();
      expect_out("wrap_f1", 1, 19'h0, 20'd4, 0, 0, 0, 0);
      tick();
      expect_out("wrap_f2", 0, 19'h0, 20'd0, 0, 0, 1, 0);
      int_ch_grant_i = 1'b0;

      // Reset mid-transfer clears everything without an event pulse.
      set_cfg(19'h20, 20'd8, 20'd0, 19'h0, 1'b0, 2'b00);
      cfg_en_i = 1'b1;
      tick();
      cfg_en_i       = 1'b0;
      int_ch_grant_i = 1'b1;
      tick();
      expect_out("rst_mid_f1", 1, 19'h21, 20'd7, 0, 0, 0, 0);
      rstn_i = 1'b0;
      tick();
      expect_out("rst_mid", 0, 19'h0, 20'd0, 0, 0, 0, 0);
      rstn_i         = 1'b1;
      int_ch_grant_i = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
